// File: rtl/pc_pkg.sv
// pc_pkg: shared state type and constants for the PC / instruction-fetch sequencer
package pc_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} fetch_state_t;
   localparam int INSTR_BYTES = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: control, redirect and instruction-memory request signals of the fetch sequencer
interface pc_fetch_ctrl_if #(parameter int w = 32);
   logic stall, branch_taken, imem_ready, imem_req, fetch_valid, misalign_err;
   logic [w-1:0] branch_target, imem_addr, pcoutput, fetch_pc;
   modport master (
      input stall, branch_taken, branch_target, imem_ready,
      output imem_req, imem_addr, pcoutput, fetch_valid, fetch_pc, misalign_err
   );
   modport slave (
      output stall, branch_taken, branch_target, imem_ready,
      input imem_req, imem_addr, pcoutput, fetch_valid, fetch_pc, misalign_err
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register and fetch sequencer; sequential +INSTR_BYTES flow,
// one-cycle redirect with squash of a coincident accept, stall to HOLD, sticky misalign error.
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int w = 32,
   parameter logic [w-1:0] RESET_PC = w'(RESET_PC_DEFAULT)
) (
   input logic clk,
   input logic rst,
   pc_fetch_ctrl_if.master bus
);
   fetch_state_t state, state_next;
   logic [w-1:0] pc, pc_next, fpc;
   logic req, fv, err, accept, redirect, misaligned, take;
   assign accept = req & bus.imem_ready;
   assign redirect = bus.branch_taken & (state != ERR);
   assign misaligned = redirect & (bus.branch_target[1:0] != 2'b00);
   assign take = accept & ~redirect;
   // a redirect freezes the state; IDLE and HOLD both follow stall
   assign state_next = misaligned ? ERR :
                       redirect ? state :
                       (state == IDLE || state == HOLD) ? (bus.stall ? HOLD : FETCH) :
                       (state == FETCH && accept && bus.stall) ? HOLD : state;
   assign pc_next = misaligned ? pc :
                    redirect ? bus.branch_target :
                    accept ? pc + w'(INSTR_BYTES) : pc;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc <= RESET_PC;
         req <= 1'b0;
         fv <= 1'b0;
         fpc <= '0;
         err <= 1'b0;
      end else begin
         state <= state_next;
         pc <= pc_next;
         req <= state_next == FETCH;
         fv <= take;
         if (take) fpc <= pc;
         if (misaligned) err <= 1'b1;
      end
   end
   assign bus.imem_req = req;
   assign bus.imem_addr = pc;
   assign bus.pcoutput = pc;
   assign bus.fetch_valid = fv;
   assign bus.fetch_pc = fpc;
   assign bus.misalign_err = err;
endmodule
